// File: rtl/rect_fill_writer.sv
// Rectangle fill writer: scans a latched rectangle in raster order, one frame buffer write per clock.
// Optional border-only drawing is enabled by defining RECT_OUTLINE_EN.
module rect_fill_writer #(
    parameter int unsigned X_MAX = 160,
    parameter int unsigned Y_MAX = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] width,
    input  logic [6:0] height,
    input  logic [2:0] color,
`ifdef RECT_OUTLINE_EN
    input  logic       outline,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] x_write,
    output logic [6:0] y_write,
    output logic [2:0] color_in,
    output logic       wren
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    logic [1:0] state_q, state_d;
    logic [8:0] x_q, x_d, x_start_q, x_start_d, x_end_q, x_end_d;
    logic [7:0] y_q, y_d, y_start_q, y_start_d, y_end_q, y_end_d;
    logic [2:0] color_q, color_d;
    logic       outline_q, outline_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       wren_q, wren_d;
    logic       outline_req;

`ifdef RECT_OUTLINE_EN
    assign outline_req = outline;
`else
    assign outline_req = 1'b0;
`endif

    // Clipped pixels are still scanned; only the write enable is dropped.
    function automatic logic pixel_on(input logic [8:0] px, input logic [7:0] py,
                                      input logic [8:0] xs, input logic [8:0] xe,
                                      input logic [7:0] ys, input logic [7:0] ye,
                                      input logic ol);
        logic in_range;
        logic on_edge;
        in_range = (px < X_LIM) && (py < Y_LIM);
        on_edge  = (px == xs) || (px == xe) || (py == ys) || (py == ye);
        return in_range && (!ol || on_edge);
    endfunction

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        y_start_d = y_start_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        color_d   = color_q;
        outline_d = outline_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wren_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    color_d   = color;
                    outline_d = outline_req;
                    if (width == 8'd0 || height == 7'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = DRAW;
                        busy_d    = 1'b1;
                        x_start_d = {1'b0, x0};
                        y_start_d = {1'b0, y0};
                        x_end_d   = {1'b0, x0} + {1'b0, width} - 9'd1;
                        y_end_d   = {1'b0, y0} + {1'b0, height} - 8'd1;
                        x_d       = x_start_d;
                        y_d       = y_start_d;
                        wren_d    = pixel_on(x_d, y_d, x_start_d, x_end_d,
                                             y_start_d, y_end_d, outline_d);
                    end
                end
            end
            DRAW: begin
                if (x_q == x_end_q && y_q == y_end_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (x_q == x_end_q) begin
                        x_d = x_start_q;
                        y_d = y_q + 8'd1;
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                    wren_d = pixel_on(x_d, y_d, x_start_q, x_end_q,
                                      y_start_q, y_end_q, outline_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            y_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wren_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            y_start_q <= y_start_d;
            x_end_q   <= x_end_d;
            y_end_q   <= y_end_d;
            color_q   <= color_d;
            outline_q <= outline_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wren_q    <= wren_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wren     = wren_q;
    assign x_write  = x_q[7:0];
    assign y_write  = y_q[6:0];
    assign color_in = color_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: raster order, timing, clipping, busy/start rules, reset abort.
`timescale 1ns/1ps
module tb_rect_fill_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] width;
    logic [6:0] height;
    logic [2:0] color;
`ifdef RECT_OUTLINE_EN
    logic       outline;
`endif
    logic       busy, done, wren;
    logic [7:0] x_write;
    logic [6:0] y_write;
    logic [2:0] color_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run capture of every write and the done/busy timing.
    int         wx[$];
    int         wy[$];
    int         wc[$];
    int         wcyc[$];
    int         done_cyc;
    int         n_busy;
    int         n_writes;
    int         n_done;

    rect_fill_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .width    (width),
        .height   (height),
        .color    (color),
`ifdef RECT_OUTLINE_EN
        .outline  (outline),
`endif
        .busy     (busy),
        .done     (done),
        .x_write  (x_write),
        .y_write  (y_write),
        .color_in (color_in),
        .wren     (wren)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic fail(input string tag, input int obs, input int exp);
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Start is sampled at edge 0; samples are taken on the falling edge of cycles 1..budget.
    task automatic run_rect(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                            input logic [6:0] ah, input logic [2:0] ac, input logic ol,
                            input int budget);
        wx.delete(); wy.delete(); wc.delete(); wcyc.delete();
        done_cyc = -1;
        n_busy   = 0;
        @(negedge clk);
        x0 = ax; y0 = ay; width = aw; height = ah; color = ac; start = 1'b1;
`ifdef RECT_OUTLINE_EN
        outline = ol;
`else
        if (ol) $display("outline request ignored in this build");
`endif
        @(negedge clk);
        start = 1'b0;
        x0 = 8'hff; y0 = 7'h7f; width = 8'hff; height = 7'h7f; color = 3'b000;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (wren) begin
                wx.push_back(int'(x_write));
                wy.push_back(int'(y_write));
                wc.push_back(int'(color_in));
                wcyc.push_back(k);
            end
            if (busy) n_busy++;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        @(negedge clk);
        n_tests++; if (int'(done) !== 0) fail("done_len", int'(done), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        x0 = 8'd5; y0 = 7'd5; width = 8'd2; height = 7'd2; color = 3'b111;
`ifdef RECT_OUTLINE_EN
        outline = 1'b0;
`endif
        // 1: reset held 3 cycles with start asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (int'(busy) !== 0) fail("rst_busy", int'(busy), 0);
        n_tests++; if (int'(done) !== 0) fail("rst_done", int'(done), 0);
        n_tests++; if (int'(wren) !== 0) fail("rst_wren", int'(wren), 0);
        n_tests++; if (int'(x_write) !== 0) fail("rst_x", int'(x_write), 0);
        n_tests++; if (int'(y_write) !== 0) fail("rst_y", int'(y_write), 0);
        n_tests++; if (int'(color_in) !== 0) fail("rst_color", int'(color_in), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_tests++; if (int'(busy) !== 0) fail("post_rst_busy", int'(busy), 0);
        n_tests++; if (int'(wren) !== 0) fail("post_rst_wren", int'(wren), 0);

        // 2: 3x2 fill at (10,20), colour 101
        run_rect(8'd10, 7'd20, 8'd3, 7'd2, 3'b101, 1'b0, 40);
        n_tests++; if (wx.size() !== 6) fail("t2_nwrites", wx.size(), 6);
        n_tests++; if (done_cyc !== 7) fail("t2_done", done_cyc, 7);
        n_tests++; if (n_busy !== 6) fail("t2_busy", n_busy, 6);
        for (int i = 0; i < 6; i++) begin
            int ox, oy, oc, ok;
            ox = (i < wx.size()) ? wx[i] : -1;
            oy = (i < wy.size()) ? wy[i] : -1;
            oc = (i < wc.size()) ? wc[i] : -1;
            ok = (i < wcyc.size()) ? wcyc[i] : -1;
            n_tests++; if (ox !== 10 + i % 3) fail("t2_x", ox, 10 + i % 3);
            n_tests++; if (oy !== 20 + i / 3) fail("t2_y", oy, 20 + i / 3);
            n_tests++; if (oc !== 5) fail("t2_col", oc, 5);
            n_tests++; if (ok !== i + 1) fail("t2_cyc", ok, i + 1);
        end

        // 3: empty rectangle
        run_rect(8'd30, 7'd30, 8'd0, 7'd5, 3'b011, 1'b0, 10);
        n_tests++; if (wx.size() !== 0) fail("t3_nwrites", wx.size(), 0);
        n_tests++; if (done_cyc !== 1) fail("t3_done", done_cyc, 1);
        n_tests++; if (n_busy !== 0) fail("t3_busy", n_busy, 0);

        // 4: rectangle straddling bottom-right corner, clipped to 4 writes
        run_rect(8'd158, 7'd118, 8'd4, 7'd4, 3'b010, 1'b0, 40);
        n_tests++; if (wx.size() !== 4) fail("t4_nwrites", wx.size(), 4);
        n_tests++; if (done_cyc !== 17) fail("t4_done", done_cyc, 17);
        n_tests++; if (n_busy !== 16) fail("t4_busy", n_busy, 16);
        n_writes = wx.size();
        if (n_writes == 4) begin
            n_tests++; if (wx[0] !== 158) fail("t4_x0", wx[0], 158);
            n_tests++; if (wy[0] !== 118) fail("t4_y0", wy[0], 118);
            n_tests++; if (wcyc[0] !== 1) fail("t4_c0", wcyc[0], 1);
            n_tests++; if (wx[1] !== 159) fail("t4_x1", wx[1], 159);
            n_tests++; if (wy[1] !== 118) fail("t4_y1", wy[1], 118);
            n_tests++; if (wcyc[1] !== 2) fail("t4_c1", wcyc[1], 2);
            n_tests++; if (wx[2] !== 158) fail("t4_x2", wx[2], 158);
            n_tests++; if (wy[2] !== 119) fail("t4_y2", wy[2], 119);
            n_tests++; if (wcyc[2] !== 5) fail("t4_c2", wcyc[2], 5);
            n_tests++; if (wx[3] !== 159) fail("t4_x3", wx[3], 159);
            n_tests++; if (wy[3] !== 119) fail("t4_y3", wy[3], 119);
            n_tests++; if (wcyc[3] !== 6) fail("t4_c3", wcyc[3], 6);
            n_tests++; if (wc[3] !== 2) fail("t4_col", wc[3], 2);
        end

        // 5: second start while busy is ignored; reset mid-draw aborts
        @(negedge clk);
        x0 = 8'd10; y0 = 7'd20; width = 8'd3; height = 7'd2; color = 3'b110; start = 1'b1;
        @(negedge clk);                       // cycle 1
        n_tests++; if (int'(x_write) !== 10) fail("t5_c1_x", int'(x_write), 10);
        x0 = 8'd50; y0 = 7'd50; color = 3'b001; start = 1'b1;
        @(negedge clk);                       // cycle 2
        start = 1'b0;
        n_tests++; if (int'(x_write) !== 11) fail("t5_c2_x", int'(x_write), 11);
        n_tests++; if (int'(y_write) !== 20) fail("t5_c2_y", int'(y_write), 20);
        n_tests++; if (int'(color_in) !== 6) fail("t5_c2_col", int'(color_in), 6);
        n_tests++; if (int'(wren) !== 1) fail("t5_c2_wren", int'(wren), 1);
        @(negedge clk);                       // cycle 3
        n_tests++; if (int'(x_write) !== 12) fail("t5_c3_x", int'(x_write), 12);
        reset = 1'b1;
        @(negedge clk);                       // cycle 4
        reset = 1'b0;
        n_tests++; if (int'(wren) !== 0) fail("t5_c4_wren", int'(wren), 0);
        n_tests++; if (int'(busy) !== 0) fail("t5_c4_busy", int'(busy), 0);
        n_writes = 0;
        n_done   = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wren) n_writes++;
            if (done) n_done++;
        end
        n_tests++; if (n_writes !== 0) fail("t5_no_writes", n_writes, 0);
        n_tests++; if (n_done !== 0) fail("t5_no_done", n_done, 0);

        // Rectangle right after an abort must still work
        run_rect(8'd0, 7'd0, 8'd1, 7'd1, 3'b100, 1'b0, 10);
        n_tests++; if (wx.size() !== 1) fail("t5b_nwrites", wx.size(), 1);
        n_tests++; if (done_cyc !== 2) fail("t5b_done", done_cyc, 2);

`ifdef RECT_OUTLINE_EN
        // 6: outline 4x3 at origin, interior (1,1),(2,1) skipped
        run_rect(8'd0, 7'd0, 8'd4, 7'd3, 3'b001, 1'b1, 40);
        n_tests++; if (wx.size() !== 10) fail("t6_nwrites", wx.size(), 10);
        n_tests++; if (done_cyc !== 13) fail("t6_done", done_cyc, 13);
        if (wcyc.size() == 10) begin
            n_tests++; if (wcyc[4] !== 5) fail("t6_c4", wcyc[4], 5);
            n_tests++; if (wcyc[5] !== 8) fail("t6_c5", wcyc[5], 8);
            n_tests++; if (wx[5] !== 3) fail("t6_x5", wx[5], 3);
            n_tests++; if (wy[5] !== 1) fail("t6_y5", wy[5], 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
